// File: rtl/div_pkg.sv
// Shared definitions for the multi-cycle divider: FSM state encoding and
// handshake/reset constants used by the execute-stage interface.
package div_pkg;

  typedef enum logic [1:0] {
    DivFree   = 2'b00,
    DivByZero = 2'b01,
    DivOn     = 2'b10,
    DivEnd    = 2'b11
  } div_state_e;

  localparam logic RstEnable         = 1'b1;
  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;
  localparam logic DivStart          = 1'b1;
  localparam logic DivStop           = 1'b0;

endpackage

// File: rtl/div.sv
// Restoring shift-subtract divider for DIV/DIVU, one quotient bit per clock.
// Returns {remainder, quotient} for HI/LO and holds it while start_i stays high.
module div
  import div_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  signed_div_i,
  input  logic [DATA_W-1:0]     opdata1_i,
  input  logic [DATA_W-1:0]     opdata2_i,
  input  logic                  start_i,
  input  logic                  annul_i,
  output logic [2*DATA_W-1:0]   result_o,
  output logic                  ready_o
);

  localparam int CNT_W = $clog2(DATA_W) + 1;
  localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(DATA_W);

  div_state_e          state;
  logic [CNT_W-1:0]    cnt;
  logic [2*DATA_W:0]   dividend;
  logic [DATA_W-1:0]   divisor;
  logic                sign1;
  logic                sign2;
  logic                signed_op;

  logic [DATA_W:0]     diff;
  logic [DATA_W-1:0]   quot_fix;
  logic [DATA_W-1:0]   rem_fix;

  // Conditional two's-complement negate, shared by operand abs and result sign fix.
  function automatic logic [DATA_W-1:0] cond_neg(input logic [DATA_W-1:0] v, input logic neg);
    return neg ? ((~v) + DATA_W'(1)) : v;
  endfunction

  always_comb begin
    diff     = {1'b0, dividend[2*DATA_W-1:DATA_W]} - {1'b0, divisor};
    quot_fix = cond_neg(dividend[DATA_W-1:0], signed_op & (sign1 ^ sign2));
    rem_fix  = cond_neg(dividend[2*DATA_W:DATA_W+1], signed_op & sign1);
  end

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      state     <= DivFree;
      cnt       <= '0;
      dividend  <= '0;
      divisor   <= '0;
      sign1     <= 1'b0;
      sign2     <= 1'b0;
      signed_op <= 1'b0;
      result_o  <= '0;
      ready_o   <= DivResultNotReady;
    end else begin
      case (state)
        DivFree: begin
          result_o <= '0;
          ready_o  <= DivResultNotReady;
          if (start_i == DivStart && !annul_i) begin
            if (opdata2_i == '0) begin
              state <= DivByZero;
            end else begin
              state     <= DivOn;
              cnt       <= '0;
              signed_op <= signed_div_i;
              sign1     <= opdata1_i[DATA_W-1];
              sign2     <= opdata2_i[DATA_W-1];
              divisor   <= cond_neg(opdata2_i, signed_div_i & opdata2_i[DATA_W-1]);
              dividend  <= {{DATA_W{1'b0}},
                            cond_neg(opdata1_i, signed_div_i & opdata1_i[DATA_W-1]),
                            1'b0};
            end
          end
        end

        DivByZero: begin
          dividend <= '0;
          result_o <= '0;
          ready_o  <= DivResultReady;
          state    <= DivEnd;
        end

        DivOn: begin
          if (annul_i) begin
            state <= DivFree;
            cnt   <= '0;
          end else if (cnt != CNT_DONE) begin
            // A borrow means the divisor did not fit: shift in a 0 quotient bit.
            if (diff[DATA_W]) begin
              dividend <= {dividend[2*DATA_W-1:0], 1'b0};
            end else begin
              dividend <= {diff[DATA_W-1:0], dividend[DATA_W-1:0], 1'b1};
            end
            cnt <= cnt + CNT_W'(1);
          end else begin
            result_o <= {rem_fix, quot_fix};
            ready_o  <= DivResultReady;
            state    <= DivEnd;
            cnt      <= '0;
          end
        end

        DivEnd: begin
          if (start_i == DivStop) begin
            state    <= DivFree;
            result_o <= '0;
            ready_o  <= DivResultNotReady;
          end
        end

        default: state <= DivFree;
      endcase
    end
  end

endmodule

// File: tb/tb_div.sv
// Scoreboard bench for the divider: stimulus pushes expected results and
// ready edges; a negedge monitor pops and checks whenever ready_o rises.
module tb_div;

  typedef struct {
    string       name;
    logic [63:0] result;
    int          ready_edge;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        signed_div;
  logic [31:0] opdata1;
  logic [31:0] opdata2;
  logic        start;
  logic        annul;
  logic [63:0] result;
  logic        ready;

  exp_t sb[$];
  exp_t cur;
  int   checks;
  int   errors;
  int   edge_cnt;
  logic prev_ready;

  div #(.DATA_W(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div),
    .opdata1_i    (opdata1),
    .opdata2_i    (opdata2),
    .start_i      (start),
    .annul_i      (annul),
    .result_o     (result),
    .ready_o      (ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) edge_cnt++;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
    end
  endtask

  // Monitor: a rising ready_o pops the next expectation; while high the result
  // must hold, and the edge that drops ready_o must also clear result_o.
  always @(negedge clk) begin
    if (ready === 1'b1 && prev_ready !== 1'b1) begin
      if (sb.size() == 0) begin
        checkOutput("unexpected_ready", 64'(ready), 64'd0);
      end else begin
        cur = sb.pop_front();
        checkOutput({cur.name, "_result"}, result, cur.result);
        checkOutput({cur.name, "_latency"}, 64'(edge_cnt), 64'(cur.ready_edge));
      end
    end else if (ready === 1'b1 && prev_ready === 1'b1) begin
      checkOutput({cur.name, "_stable"}, result, cur.result);
    end else if (ready !== 1'b1 && prev_ready === 1'b1) begin
      checkOutput({cur.name, "_clear"}, result, 64'd0);
    end
    prev_ready = ready;
  end

  task automatic applyStimulus(input string name, input logic sgn, input logic [31:0] a,
                               input logic [31:0] b, input logic [63:0] expected,
                               input int latency, input bit scramble);
    exp_t e;
    bit   got;
    @(negedge clk);
    signed_div = sgn;
    opdata1    = a;
    opdata2    = b;
    start      = 1'b1;
    e.name       = name;
    e.result     = expected;
    e.ready_edge = edge_cnt + latency;
    sb.push_back(e);
    got = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (ready === 1'b1) begin
        got = 1'b1;
        break;
      end
      if (scramble) begin
        opdata1 = $urandom;
        opdata2 = $urandom;
      end
    end
    if (!got) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s_timeout actual=no_ready expected=ready", name);
      if (sb.size() > 0) void'(sb.pop_back());
    end else begin
      repeat (3) @(negedge clk);
    end
    start = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    logic seen;
    checks     = 0;
    errors     = 0;
    edge_cnt   = 0;
    prev_ready = 1'b0;
    rst        = 1'b1;
    signed_div = 1'b0;
    opdata1    = '0;
    opdata2    = '0;
    start      = 1'b0;
    annul      = 1'b0;

    repeat (3) @(negedge clk);
    checkOutput("reset_ready", 64'(ready), 64'd0);
    checkOutput("reset_result", result, 64'd0);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("idle_ready", 64'(ready), 64'd0);

    applyStimulus("u_7_2",        1'b0, 32'd7,        32'd2,        64'h00000001_00000003, 34, 1'b0);
    applyStimulus("s_m7_2",       1'b1, 32'hFFFFFFF9, 32'd2,        64'hFFFFFFFF_FFFFFFFD, 34, 1'b0);
    applyStimulus("s_7_m2",       1'b1, 32'd7,        32'hFFFFFFFE, 64'h00000001_FFFFFFFD, 34, 1'b0);
    applyStimulus("div_zero",     1'b0, 32'd5,        32'd0,        64'h0,                  2, 1'b0);
    applyStimulus("u_max_1",      1'b0, 32'hFFFFFFFF, 32'd1,        64'h00000000_FFFFFFFF, 34, 1'b0);
    applyStimulus("s_min_m1",     1'b1, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 34, 1'b0);
    applyStimulus("s_m100_7",     1'b1, 32'hFFFFFF9C, 32'd7,        64'hFFFFFFFE_FFFFFFF2, 34, 1'b0);

    // Annul in the 10th DivOn cycle, then a fresh division must still work.
    @(negedge clk);
    signed_div = 1'b0;
    opdata1    = 32'd50;
    opdata2    = 32'd3;
    start      = 1'b1;
    repeat (10) @(negedge clk);
    annul = 1'b1;
    @(negedge clk);
    annul = 1'b0;
    start = 1'b0;
    seen  = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      seen = seen | (ready === 1'b1);
    end
    checkOutput("annul_no_ready", 64'(seen), 64'd0);
    applyStimulus("u_100_7",      1'b0, 32'd100,      32'd7,        64'h00000002_0000000E, 34, 1'b0);

    // Reset pulsed in the middle of an iteration sequence.
    @(negedge clk);
    opdata1 = 32'd1000;
    opdata2 = 32'd3;
    start   = 1'b1;
    repeat (15) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("rst_mid_ready", 64'(ready), 64'd0);
    checkOutput("rst_mid_result", result, 64'd0);
    rst   = 1'b0;
    start = 1'b0;
    seen  = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      seen = seen | (ready === 1'b1);
    end
    checkOutput("rst_no_ready", 64'(seen), 64'd0);

    applyStimulus("u_1000_7_scr", 1'b0, 32'd1000,     32'd7,        64'h00000006_0000008E, 34, 1'b1);

    checkOutput("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
